// File: rtl/debounce_pkg.sv
// ----------------------------------------------------------------------------
// debounce_pkg
//   Shared constants and helpers for the multi-channel input debouncer.
//
//   Contents
//     DEB_DEFAULT_STABLE    default number of consecutive qualified samples
//                           a new level must hold before the clean output flips
//     DEB_DEFAULT_CHANNELS  default number of independent input channels
//     DEB_CNT_W(n)          width of a counter able to hold 0..n, i.e.
//                           clog2(n+1); never less than 1 bit
// ----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEB_DEFAULT_STABLE   = 4;
    localparam int DEB_DEFAULT_CHANNELS = 4;

    // Width of the per-channel stability counter. The counter is cleared on
    // every flip, so it only ever reaches n-1, but sizing for 0..n keeps the
    // n=1 case at a legal 1-bit width.
    function automatic int DEB_CNT_W(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
//   Debouncer for a single bit: a 2-flop synchroniser, a symmetric stability
//   counter and the registered clean level. Both rising and falling changes
//   must be seen on STABLE_CYCLES consecutive qualified samples before the
//   clean level follows the synchronised input.
//
//   Optional feature (macro DEBOUNCE_EDGE_EN)
//     Defined  : rise_pulse/fall_pulse are registered one-cycle strobes that
//                are high on the same edge the clean level changes.
//     Undefined: rise_pulse/fall_pulse are tied to 0 and no pulse flops exist.
//
//   Parameters
//     STABLE_CYCLES  qualified samples required before a flip (>=1)
//     RESET_VAL      reset level of the synchroniser and clean flop
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     sample_en   sample qualifier; counter advances only when high
//     noisy_in    raw asynchronous input bit
//     clean_out   debounced level (registered)
//     rise_pulse  one-cycle strobe on a 0->1 change of clean_out
//     fall_pulse  one-cycle strobe on a 1->0 change of clean_out
// ----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_DEFAULT_STABLE,
    parameter bit RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic noisy_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = DEB_CNT_W(STABLE_CYCLES);

    // Count value at which the next differing sample completes the run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             clean;
    logic             differs;
    logic             flip;

    // A flip happens on a qualified sample that differs from the clean level
    // when the counter already holds STABLE_CYCLES-1 differing samples.
    always_comb begin
        differs = (sync2 != clean);
        flip    = sample_en && differs && (cnt == CNT_LAST);
    end

    // Two-flop synchroniser. It runs on every clock edge so that sample_en
    // only gates the decision logic, never the metastability filtering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= noisy_in;
            sync2 <= sync1;
        end
    end

    // Stability counter and clean level. Any qualified sample that agrees
    // with the clean level discards the partial count, so a glitch shorter
    // than STABLE_CYCLES samples never reaches the output. Unqualified
    // cycles pause the count rather than clearing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            clean <= RESET_VAL;
        end else if (sample_en) begin
            if (!differs) begin
                cnt <= '0;
            end else if (flip) begin
                clean <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    assign clean_out = clean;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Edge strobes are decoded from the same condition that flips the clean
    // flop, so they line up with the clean_out change and cannot both be
    // high. Reset never produces a strobe even if it changes clean_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= flip &&  sync2;
            fall_q <= flip && !sync2;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/multi_debouncer.sv
// ----------------------------------------------------------------------------
// multi_debouncer
//   N-channel input debouncer for buttons, switches and other bouncing
//   inputs. One instance serves a whole input bank; each channel is an
//   independent debounce_channel with its own synchroniser and counter.
//
//   Optional feature (macro DEBOUNCE_EDGE_EN)
//     Defined  : rise_pulse/fall_pulse carry registered one-cycle strobes.
//     Undefined: rise_pulse/fall_pulse are constant 0; ports remain present.
//
//   Parameters
//     CHANNELS       number of independent channels (>=1)
//     STABLE_CYCLES  consecutive qualified samples before a flip (>=1)
//     RESET_VAL      reset level of synchronisers and clean_out (0/1)
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     sample_en   sample qualifier shared by all channels
//     noisy_in    raw asynchronous inputs, one bit per channel
//     clean_out   debounced levels (registered)
//     rise_pulse  per-channel one-cycle strobe on 0->1 of clean_out
//     fall_pulse  per-channel one-cycle strobe on 1->0 of clean_out
// ----------------------------------------------------------------------------
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEB_DEFAULT_CHANNELS,
    parameter int STABLE_CYCLES = DEB_DEFAULT_STABLE,
    parameter bit RESET_VAL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    // Channels share only clock, reset and the sample qualifier; there is no
    // cross-channel state, so several channels may flip on the same edge.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sample_en  (sample_en),
            .noisy_in   (noisy_in[i]),
            .clean_out  (clean_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

endmodule : multi_debouncer
